// File: rtl/fp_defs_pkg.sv
// Shared definitions for the single-precision FP square-root unit.
package fp_defs;

  // Default datapath geometry for single precision
  localparam int FP_IW    = 26;  // radicand width, MSB must be 0
  localparam int FP_IFRAC = 23;  // radicand fraction bits
  localparam int FP_OW    = 26;  // root width: 1 integer bit + 25 fraction bits

  // Iterative core state encoding
  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_RUN  = 2'd1,
    SQ_FIN  = 2'd2
  } sqrt_state_e;

  // Rounding modes used by the rounding/exception stage
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Special single-precision encodings
  localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] SP_PINF = 32'h7F80_0000;
  localparam logic [31:0] SP_NINF = 32'hFF80_0000;
  localparam logic [31:0] SP_PZERO = 32'h0000_0000;
  localparam logic [31:0] SP_NZERO = 32'h8000_0000;

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root step: brings down two radicand bits and
// decides one root bit. Purely combinational.
module sqrt_step
  import fp_defs::*;
#(
  parameter int OW = FP_OW
) (
  input  logic [OW+1:0] rem_i,
  input  logic [1:0]    bits_i,
  input  logic [OW-1:0] root_i,
  output logic [OW+1:0] rem_o,
  output logic [OW-1:0] root_o
);

  // Wide working copies; the remainder invariant (rem <= 2*root) keeps the
  // upper two bits zero, so truncating the result back loses nothing.
  logic [OW+3:0] r_full;
  logic [OW+3:0] t_full;
  logic [OW+3:0] d_full;
  logic          ge;

  // Trial subtract and restore decision
  always_comb begin
    r_full = {rem_i, bits_i};
    t_full = {2'b00, root_i, 2'b01};
    d_full = r_full - t_full;
    ge     = (r_full >= t_full);
    rem_o  = (OW+2)'(ge ? d_full : r_full);
    root_o = {root_i[OW-2:0], ge};
  end

endmodule

// File: rtl/mant_sqrt_iter.sv
// Iterative restoring mantissa square root, one root bit per clock.
// Produces floor(sqrt(in * 2^(2*(OW-1)-IFRAC))) plus a sticky bit.
module mant_sqrt_iter
  import fp_defs::*;
#(
  parameter int IW    = FP_IW,
  parameter int IFRAC = FP_IFRAC,
  parameter int OW    = FP_OW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] in,
  output logic [OW-1:0] out,
  output logic          sticky,
  output logic          busy,
  output logic          done
);

  localparam int PW = 2 * OW;
  localparam int SH = 2 * (OW - 1) - IFRAC;
  localparam int RW = OW + 2;
  localparam int CW = $clog2(OW + 1);

  sqrt_state_e   state_q, state_d;
  logic [PW-1:0] pad_q, pad_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [OW-1:0] root_q, root_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_q, out_d;
  logic          sticky_q, sticky_d;

  logic [RW-1:0] rem_nx;
  logic [OW-1:0] root_nx;
  logic [IW-1:0] in_m;
  logic          load;
  logic          last;

  sqrt_step #(.OW(OW)) u_step (
    .rem_i  (rem_q),
    .bits_i (pad_q[PW-1 -: 2]),
    .root_i (root_q),
    .rem_o  (rem_nx),
    .root_o (root_nx)
  );

  // The MSB of the radicand is a caller error; drop it silently.
  assign in_m = in & {1'b0, {(IW-1){1'b1}}};
  // A new operation may load from IDLE or from the FIN (done) cycle.
  assign load = start && (state_q != SQ_RUN);
  assign last = (cnt_q == CW'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SQ_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SQ_IDLE: if (start) state_d = SQ_RUN;
      SQ_RUN:  if (last)  state_d = SQ_FIN;
      SQ_FIN:  state_d = start ? SQ_RUN : SQ_IDLE;
      default: state_d = SQ_IDLE;
    endcase
  end

  // Datapath next values: load, iterate, and capture the result on the final step
  always_comb begin
    pad_d    = pad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    sticky_d = sticky_q;
    if (load) begin
      pad_d  = PW'(in_m) << SH;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = CW'(OW);
    end else if (state_q == SQ_RUN) begin
      pad_d  = pad_q << 2;
      rem_d  = rem_nx;
      root_d = root_nx;
      cnt_d  = cnt_q - CW'(1);
      // Result registers update on the edge entering FIN so they are
      // valid alongside done.
      if (last) begin
        out_d    = root_nx;
        sticky_d = |rem_nx;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      pad_q    <= pad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      sticky_q <= sticky_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy   = (state_q == SQ_RUN);
    done   = (state_q == SQ_FIN);
    out    = out_q;
    sticky = sticky_q;
  end

endmodule

// File: tb/tb_mant_sqrt_iter.sv
// Directed and randomized checks for the iterative mantissa square root.
module tb_mant_sqrt_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [25:0] in_r;
  logic [25:0] out;
  logic        sticky;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  mant_sqrt_iter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in     (in_r),
    .out    (out),
    .sticky (sticky),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: binary search for floor(sqrt(P)).
  function automatic void ref_sqrt(input logic [25:0] v, output logic [25:0] r,
                                   output logic s);
    longint unsigned p, lo, hi, mid;
    p  = longint'(v & 26'h1FF_FFFF) << 27;
    lo = 0;
    hi = 64'h400_0000;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= p) lo = mid;
      else hi = mid;
    end
    r = lo[25:0];
    s = (lo * lo != p);
  endfunction

  // Launch one operation and wait (bounded) for done; leaves the bench in the done cycle.
  task automatic run_op(input logic [25:0] v, output int lat, output int busy_err);
    in_r = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_err = 0;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) busy_err++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    in_r = '0;
    #1;
    n_tests++;
    if ({out, sticky, busy, done} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got out=%h sticky=%b busy=%b done=%b, want all 0",
               out, sticky, busy, done);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [25:0] vin  [5] = '{26'h080_0000, 26'h100_0000, 26'h120_0000, 26'h000_0000, 26'h280_0000};
    logic [25:0] vout [5] = '{26'h200_0000, 26'h2D4_13CC, 26'h300_0000, 26'h000_0000, 26'h200_0000};
    logic        vst  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat, berr;
    for (int i = 0; i < 5; i++) begin
      run_op(vin[i], lat, berr);
      n_tests++;
      if (lat !== 26 || berr !== 0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_timing[%0d]: got lat=%0d busy_err=%0d busy=%b, want 26/0/0",
                 i, lat, berr, busy);
      end
      n_tests++;
      if (out !== vout[i] || sticky !== vst[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: in=%h got out=%h sticky=%b, want out=%h sticky=%b",
                 i, vin[i], out, sticky, vout[i], vst[i]);
      end
      tick();
      n_tests++;
      if (done !== 1'b0 || out !== vout[i]) begin
        n_fail++;
        $display("FAIL directed_pulse_hold[%0d]: got done=%b out=%h, want done=0 out=%h",
                 i, done, out, vout[i]);
      end
    end
  endtask

  task automatic test_busy_ignore_back_to_back();
    int errs;
    in_r = 26'h100_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_r = 26'h080_0000;
    errs = 0;
    for (int c = 0; c < 26; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) errs++;
      start = (c == 3 || c == 20);
      tick();
    end
    start = 1'b0;
    n_tests++;
    if (errs !== 0 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_timing: got errs=%0d done=%b busy=%b, want 0/1/0", errs, done, busy);
    end
    n_tests++;
    if (out !== 26'h2D4_13CC || sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_result: got out=%h sticky=%b, want 2d413cc/1", out, sticky);
    end
    // start in the done cycle is accepted on the next edge
    in_r = 26'h080_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_r = 26'h3FF_FFFF;
    errs = 0;
    for (int c = 0; c < 26; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) errs++;
      if (c == 10) begin
        n_tests++;
        if (out !== 26'h2D4_13CC || sticky !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_hold: got out=%h sticky=%b, want 2d413cc/1", out, sticky);
        end
      end
      tick();
    end
    n_tests++;
    if (errs !== 0 || done !== 1'b1 || out !== 26'h200_0000 || sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_result: got errs=%0d done=%b out=%h sticky=%b, want 0/1/2000000/0",
               errs, done, out, sticky);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_pulse: got done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_reset_abort();
    int dones, lat, berr;
    in_r = 26'h100_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({out, sticky, busy, done} !== 29'd0) begin
      n_fail++;
      $display("FAIL abort_clear: got out=%h sticky=%b busy=%b done=%b, want all 0",
               out, sticky, busy, done);
    end
    tick();
    tick();
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) dones++;
      tick();
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", dones);
    end
    run_op(26'h120_0000, lat, berr);
    n_tests++;
    if (lat !== 26 || berr !== 0 || out !== 26'h300_0000 || sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_restart: got lat=%0d busy_err=%0d out=%h sticky=%b, want 26/0/3000000/0",
               lat, berr, out, sticky);
    end
    tick();
  endtask

  task automatic test_random();
    logic [25:0] v, r_exp;
    logic        s_exp;
    int lat, berr;
    for (int i = 0; i < 150; i++) begin
      v = 26'h080_0000 + 26'($urandom_range(0, 32'h17F_FFFF));
      ref_sqrt(v, r_exp, s_exp);
      run_op(v, lat, berr);
      n_tests++;
      if (lat !== 26 || berr !== 0 || out !== r_exp || sticky !== s_exp) begin
        n_fail++;
        $display("FAIL random[%0d]: in=%h got lat=%0d busy_err=%0d out=%h sticky=%b, want 26/0/%h/%b",
                 i, v, lat, berr, out, sticky, r_exp, s_exp);
      end
      tick();
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL random_pulse[%0d]: got done=%b, want 0", i, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
